// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives rows one-hot, synchronizes and debounces the columns,
// and latches the first accepted key with a one-cycle new-key strobe.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic       key_pulse
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e          state_q, state_d;
  logic [3:0]      col_m_q, col_s_q;
  logic [DivW-1:0] div_q, div_d;
  // Shared by press debounce and release debounce; the two never overlap.
  logic [DebW-1:0] cnt_q, cnt_d;
  logic [3:0]      row_q, row_d;
  logic [3:0]      cand_row_q, cand_row_d;
  logic [3:0]      cand_col_q, cand_col_d;
  logic [3:0]      key_row_q, key_row_d;
  logic [3:0]      key_col_q, key_col_d;
  logic            key_valid_q, key_valid_d;
  logic            key_pulse_q, key_pulse_d;

  logic            col_onehot;
  logic [3:0]      row_next;

  assign col_onehot = (col_s_q != 4'd0) && ((col_s_q & (col_s_q - 4'd1)) == 4'd0);
  assign row_next   = {row_q[2:0], row_q[3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_m_q     <= 4'd0;
      col_s_q     <= 4'd0;
      state_q     <= StScan;
      div_q       <= '0;
      cnt_q       <= '0;
      row_q       <= 4'b0001;
      cand_row_q  <= 4'd0;
      cand_col_q  <= 4'd0;
      key_row_q   <= 4'd0;
      key_col_q   <= 4'd0;
      key_valid_q <= 1'b0;
      key_pulse_q <= 1'b0;
    end else begin
      col_m_q     <= col;
      col_s_q     <= col_m_q;
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      key_row_q   <= key_row_d;
      key_col_q   <= key_col_d;
      key_valid_q <= key_valid_d;
      key_pulse_q <= key_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    key_row_d   = key_row_q;
    key_col_d   = key_col_q;
    key_valid_d = key_valid_q;
    key_pulse_d = 1'b0;

    case (state_q)
      StScan: begin
        if (div_q == DivMax) begin
          div_d = '0;
          if (col_onehot) begin
            cand_row_d = row_q;
            cand_col_d = col_s_q;
            cnt_d      = '0;
            state_d    = StDebounce;
          end else begin
            row_d = row_next;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StDebounce: begin
        if (col_s_q != cand_col_q) begin
          div_d   = '0;
          state_d = StScan;
        end else if (cnt_q == DebMax) begin
          key_row_d   = cand_row_q;
          key_col_d   = cand_col_q;
          key_valid_d = 1'b1;
          key_pulse_d = 1'b1;
          state_d     = StHeld;
        end else begin
          cnt_d = cnt_q + DebW'(1);
        end
      end

      StHeld: begin
        if (col_s_q == 4'd0) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end

      StRelease: begin
        if (col_s_q != 4'd0) begin
          state_d = StHeld;
        end else if (cnt_q == DebMax) begin
          key_valid_d = 1'b0;
          row_d       = row_next;
          div_d       = '0;
          state_d     = StScan;
        end else begin
          cnt_d = cnt_q + DebW'(1);
        end
      end

      default: state_d = StScan;
    endcase
  end

  assign row       = row_q;
  assign key_row   = key_row_q;
  assign key_col   = key_col_q;
  assign key_valid = key_valid_q;
  assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8 and a simple
// keypad model that returns press_col whenever the driven row hits press_row.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col;
  logic [3:0] row, key_row, key_col;
  logic       key_valid, key_pulse;

  logic [3:0] press_row = 4'd0;
  logic [3:0] press_col = 4'd0;

  int tests = 0;
  int failed = 0;
  int pulse_cnt = 0;
  int bad_row = 0;
  int base;
  int n;

  always #5 clk = ~clk;

  assign col = ((row & press_row) != 4'd0) ? press_col : 4'd0;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_valid(key_valid),
    .key_pulse(key_pulse)
  );

  always @(negedge clk) begin
    if (key_pulse === 1'b1) pulse_cnt++;
    if (!$onehot(row)) bad_row++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples land 1 time unit after the falling edge, well away from the rising edge.
  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
  endtask

  task automatic wait_row(input logic [3:0] r, output int cnt);
    cnt = 0;
    while (row !== r && cnt < 100) begin
      tick(1);
      cnt++;
    end
  endtask

  task automatic wait_pulse(output int cnt);
    cnt = 0;
    while (key_pulse !== 1'b1 && cnt < 100) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    // Reset values
    tick(2);
    check("rst_row", row, 4'b0001);
    check("rst_key_row", key_row, 4'd0);
    check("rst_key_col", key_col, 4'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_pulse", key_pulse, 1'b0);

    // No key: row dwell of 4 cycles per row, full rotation
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("idle_row_%0d", i), row, 32'(4'b0001 << ((i / 4) % 4)));
      check($sformatf("idle_flags_%0d", i), {key_valid, key_pulse}, 2'b00);
      tick(1);
    end

    // Key '5': row 0100, col 0010
    press_row = 4'b0100;
    press_col = 4'b0010;
    base = pulse_cnt;
    do_reset();
    wait_row(4'b0100, n);
    check("k5_row_reached", row, 4'b0100);
    wait_pulse(n);
    check("k5_latency", n, 12);
    check("k5_row", row, 4'b0100);
    check("k5_key_row", key_row, 4'b0100);
    check("k5_key_col", key_col, 4'b0010);
    check("k5_valid", key_valid, 1'b1);
    tick(1);
    check("k5_pulse_one_cycle", key_pulse, 1'b0);
    tick(20);
    check("k5_held_valid", key_valid, 1'b1);
    check("k5_held_row", row, 4'b0100);
    check("k5_pulse_count", pulse_cnt - base, 1);
    press_row = 4'd0;
    tick(10);
    check("k5_rel_valid_before", key_valid, 1'b1);
    tick(1);
    check("k5_rel_valid_after", key_valid, 1'b0);
    check("k5_rel_row_next", row, 4'b1000);
    check("k5_rel_key_row_kept", key_row, 4'b0100);

    // Press bounce: toggle every 3 cycles for 30 cycles, then stable
    press_row = 4'b0100;
    press_col = 4'b0010;
    base = pulse_cnt;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(3);
      press_col = press_col ^ 4'b0010;
    end
    check("bounce_no_pulse", pulse_cnt - base, 0);
    check("bounce_no_valid", key_valid, 1'b0);
    wait_pulse(n);
    check("bounce_pulse_seen", key_pulse, 1'b1);
    tick(20);
    check("bounce_pulse_count", pulse_cnt - base, 1);
    check("bounce_key_col", key_col, 4'b0010);

    // Release bounce with key 'C': row 1000, col 0001
    press_row = 4'b1000;
    press_col = 4'b0001;
    base = pulse_cnt;
    do_reset();
    wait_pulse(n);
    check("kc_latency", n, 24);
    tick(5);
    press_col = 4'd0;
    tick(5);
    press_col = 4'b0001;
    tick(2);
    press_col = 4'd0;
    tick(10);
    check("kc_valid_before", key_valid, 1'b1);
    tick(1);
    check("kc_valid_after", key_valid, 1'b0);
    check("kc_row_next", row, 4'b0001);
    check("kc_key_row_kept", key_row, 4'b1000);
    check("kc_key_col_kept", key_col, 4'b0001);
    check("kc_pulse_count", pulse_cnt - base, 1);

    // Two column bits at evaluation: keep rotating, no acceptance
    press_row = 4'b0010;
    press_col = 4'b0011;
    base = pulse_cnt;
    do_reset();
    tick(40);
    check("dual_no_pulse", pulse_cnt - base, 0);
    check("dual_no_valid", key_valid, 1'b0);
    wait_row(4'b0100, n);
    check("dual_rotating", row, 4'b0100);

    // Second key added while held: first key wins
    press_row = 4'b0001;
    press_col = 4'b0100;
    base = pulse_cnt;
    do_reset();
    wait_pulse(n);
    check("second_first_pulse", key_pulse, 1'b1);
    press_col = 4'b0110;
    tick(20);
    check("second_key_row", key_row, 4'b0001);
    check("second_key_col", key_col, 4'b0100);
    check("second_valid", key_valid, 1'b1);
    check("second_pulse_count", pulse_cnt - base, 1);

    // Async reset 3 cycles into debounce
    press_row = 4'b0100;
    press_col = 4'b0010;
    base = pulse_cnt;
    do_reset();
    wait_row(4'b0100, n);
    tick(7);
    #1;
    reset = 1'b0;
    #1;
    check("arst_row", row, 4'b0001);
    check("arst_key_row", key_row, 4'd0);
    check("arst_key_col", key_col, 4'd0);
    check("arst_valid", key_valid, 1'b0);
    check("arst_pulse", key_pulse, 1'b0);
    press_row = 4'd0;
    tick(3);
    reset = 1'b1;
    tick(30);
    check("arst_no_pulse", pulse_cnt - base, 0);

    check("row_always_onehot", bad_row, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Drives the 4x4 keypad rows one-hot and samples the column lines. It debounces a single key press and presents the stable row/column pair, plus a one-cycle new-key pulse. Sits between the keypad pins and scanDecoder: key_row feeds scanDecoder r, and key_col[0..3] feed c0..c3. This is the driving end of the same row/column interface that scanDecoder decodes.

Parameters:
SCAN_DIV, 1000, clk cycles each row is driven before its columns are evaluated; must be >= 3 so the synchronizer settles.
DEBOUNCE_CYCLES, 20000, consecutive stable clk cycles required to accept a press and to accept a release; must be >= 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
col  input  4  raw column lines, active-high, asynchronous to clk; bit i = column c_i
row  output  4  row drive, one-hot active-high, format {r3,r2,r1,r0}
key_row  output  4  latched row of the accepted key, one-hot, same format as row
key_col  output  4  latched column of the accepted key, one-hot; bit i = c_i
key_valid  output  1  high while the accepted key is held, including its release debounce
key_pulse  output  1  one-cycle strobe on acceptance of a new key

Behaviour:
- Reset (reset low, async):
  - row=4'b0001; key_row=0, key_col=0, key_valid=0, key_pulse=0.
  - State SCAN; all counters 0; synchronizer flops 0.
- col passes through a 2-flop synchronizer, giving col_s. All decisions use col_s.
- SCAN:
  - div_cnt counts 0..SCAN_DIV-1 while row is held.
  - At div_cnt==SCAN_DIV-1, evaluate col_s:
    - exactly one bit set: capture row/col_s into cand_row/cand_col, go to DEBOUNCE, keep row, deb_cnt=0.
    - zero bits or two or more bits: rotate row left (0001->0010->0100->1000->0001), div_cnt=0.
- DEBOUNCE:
  - row is held.
  - Each cycle col_s==cand_col: deb_cnt++.
  - Any cycle col_s!=cand_col: back to SCAN on the same row, div_cnt=0.
  - When deb_cnt reaches DEBOUNCE_CYCLES-1 with col_s still matching:
    - go to HELD;
    - load key_row=cand_row, key_col=cand_col;
    - key_valid=1 and key_pulse=1, both registered, visible the next cycle.
- HELD:
  - row is held; key_pulse=0.
  - col_s==0 -> RELEASE, rel_cnt=0.
  - Any nonzero col_s (including extra keys pressed) -> stay; latched key unchanged; no new pulse (first key wins).
- RELEASE:
  - col_s==0 each cycle -> rel_cnt++.
  - col_s nonzero -> back to HELD, no pulse (bounce on release).
  - When rel_cnt reaches DEBOUNCE_CYCLES-1:
    - go to SCAN with key_valid=0;
    - key_row/key_col keep their last value;
    - rotate row to the next row, div_cnt=0.
- key_pulse is high for exactly one cycle per accepted press and never high in any other state.
- Latency from the col pin going stable to key_pulse: 2 (synchronizer) + remaining dwell + DEBOUNCE_CYCLES + 1 cycles.
- row is always exactly one-hot; never 0 and never multi-hot, including immediately after reset deassertion.
- Reset asserted mid-debounce or mid-held: immediately returns all outputs to reset values, with no pulse.

Test Plan:
All tests use SCAN_DIV=4, DEBOUNCE_CYCLES=8.
- No key pressed: after reset release, row sequence is 0001 x4 cycles, 0010 x4, 0100 x4, 1000 x4, 0001; key_valid=0 and key_pulse=0 throughout.
- Key '5' (col = 4'b0010 only while row==4'b0100):
  - scanning stops with row=0100;
  - key_pulse=1 for exactly one cycle, 8 cycles after detection;
  - key_row=0100, key_col=0010 (scanDecoder output 4'b0101);
  - key_valid stays 1 while the key is held.
- Press bounce: col toggles 0010/0000 every 3 cycles for 30 cycles, then stays 0010 → no pulse during bouncing; exactly one pulse after 8 stable cycles.
- Release bounce:
  - with key 'C' held (row 1000, col 0001), drop col to 0 for 5 cycles, reassert for 2, then drop → no second pulse;
  - key_valid falls 8 cycles after the final drop;
  - row then advances to 0001.
- Two keys:
  - two column bits set at evaluation → row keeps rotating with no pulse;
  - a second key added while HELD → key_row/key_col unchanged and no pulse.
- Async reset asserted 3 cycles into DEBOUNCE → row=0001 and all key outputs 0 in the same cycle, with no key_pulse ever seen.
